wb_load_align_stage: RTL

- Parametrised writeback stage between MEM and the register file.
- Accepts MEM results through a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Aligns and sign/zero-extends load data (LB/LH/LW/LBU/LHU), flags misaligned loads, suppresses writes to x0, and drives one registered regfile write port plus forwarding outputs.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_skid_buf.sv | 63 ++++++
 rtl/wb_load_align_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and decode constants for the writeback load-align stage.
package wb_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

  // Entry fields are sized for the widest legal configuration; the top slices them down.
  localparam int DATA_MAX_W = 64;
  localparam int ADDR_MAX_W = 8;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] waddr;
    logic [DATA_MAX_W-1:0] wdata;
    logic                  wen;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Generic 1- or 2-entry valid/ready buffer with flush; in_ready_o is a register,
// so there is no combinational path from out_ready_i to in_ready_o.
module wb_skid_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             ready_q;
  logic             wr_idx;
  logic             push, pop;

  assign push        = in_valid_i && ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign in_ready_o  = ready_q;
  // When full, a push only coincides with a pop, so writing the head slot is safe.
  assign wr_idx      = (DEPTH == 1) ? 1'b0 : (rd_ptr_q ^ count_q[0]);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop && (DEPTH == 2)) rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= (count_d != 2'(DEPTH));
    end
  end

  // NOTE: payload storage is not reset; consumers only look at it while out_valid_o is high.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wr_idx] <= in_data_i;
  end

endmodule

// File: rtl/wb_load_align_stage.sv
// Writeback stage: aligns/extends load data on entry, buffers results in a skid
// buffer and drives one regfile write port plus forwarding from the head entry.
module wb_load_align_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instc_i,
  input  logic                  mem_rena_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic [DATA_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     alu_res_i,
  input  logic                  reg_wena_i,
  input  logic [REG_ADDR_W-1:0] reg_addr_i,
  input  logic                  rf_ready_i,
  output logic                  rf_wena_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0]     rf_wdata_o,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0]     fwd_data_o,
  output logic                  misalign_o,
  output logic [DATA_W-1:0]     misalign_addr_o
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  function automatic logic [DATA_W-1:0] align_load(input load_f3_e f3,
                                                    input logic [DATA_W-1:0] raw,
                                                    input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (f3)
      F3_LB:   align_load = DATA_W'($signed(sh[7:0]));
      F3_LBU:  align_load = DATA_W'(sh[7:0]);
      F3_LH:   align_load = DATA_W'($signed(sh[15:0]));
      F3_LHU:  align_load = DATA_W'(sh[15:0]);
      F3_LW:   align_load = DATA_W'($signed(sh[31:0]));
      F3_LWU:  align_load = DATA_W'(sh[31:0]);
      default: align_load = sh;
    endcase
  endfunction

  function automatic logic is_misaligned(input load_f3_e f3, input logic [OFF_W-1:0] off);
    case (f3)
      F3_LH, F3_LHU: is_misaligned = off[0];
      F3_LW, F3_LWU: is_misaligned = (off[1:0] != 2'b00);
      F3_LD:         is_misaligned = (off != '0);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

  load_f3_e          f3;
  logic [OFF_W-1:0]  off;
  logic              is_load, load_mis, accept, misalign_d;
  logic              misalign_q;
  logic [DATA_W-1:0] misalign_addr_q;
  wb_entry_t         in_entry, buf_head;
  logic              buf_valid, buf_out_ready, head_wr;

  assign f3       = load_f3_e'(instc_i[14:12]);
  assign off      = mem_addr_i[OFF_W-1:0];
  assign is_load  = mem_rena_i && (instc_i[6:0] == OPC_LOAD);
  assign load_mis = is_load && is_misaligned(f3, off);
  assign accept   = in_valid_i && in_ready_o;

  always_comb begin
    in_entry       = '0;
    in_entry.waddr = ADDR_MAX_W'(reg_addr_i);
    in_entry.wdata = DATA_MAX_W'(is_load ? align_load(f3, mem_rdata_i, off) : alu_res_i);
    in_entry.wen   = reg_wena_i && (reg_addr_i != '0);
  end

  wb_skid_buf #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .arst        (arst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i && !load_mis),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_entry),
    .out_valid_o (buf_valid),
    .out_ready_i (buf_out_ready),
    .out_data_o  (buf_head)
  );

  // Silent entries (no write or rd=x0) retire without waiting for the regfile grant.
  assign head_wr       = buf_valid && buf_head.wen;
  assign buf_out_ready = !buf_head.wen || rf_ready_i;

  assign rf_wena_o   = head_wr;
  assign rf_waddr_o  = head_wr ? buf_head.waddr[REG_ADDR_W-1:0] : '0;
  assign rf_wdata_o  = head_wr ? buf_head.wdata[DATA_W-1:0] : '0;
  assign fwd_valid_o = head_wr;
  assign fwd_addr_o  = rf_waddr_o;
  assign fwd_data_o  = rf_wdata_o;

  assign misalign_d = accept && load_mis && !flush_i;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q <= misalign_d;
      if (misalign_d) misalign_addr_q <= mem_addr_i;
    end
  end

  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

  logic unused_bits;
  assign unused_bits = ^{instc_i[31:15], instc_i[11:7], buf_head.waddr, buf_head.wdata};

endmodule
